// File: rtl/fatori_mon_pkg.sv
// Shared types and helpers for the fatori_mon qualified voter.
// Optional readmission is enabled by defining FATORI_MON_READMIT_EN.
package fatori_mon_pkg;

  typedef enum logic [1:0] {
    REP_ACTIVE  = 2'd0,
    REP_SUSPECT = 2'd1,
    REP_QUAR    = 2'd2
  } rep_state_e;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_QUAR    = 2'd1,
    EVT_READMIT = 2'd2
  } evt_kind_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    if (v >= max_v) begin
      return max_v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fatori_mon_voter_qual_tracker.sv
// Per-replica disagreement tracker: state FSM, mismatch run, saturating error count and,
// with FATORI_MON_READMIT_EN, the rehabilitation run of a quarantined replica.
module fatori_mon_rep_tracker
  import fatori_mon_pkg::*;
#(
  parameter int W           = 32,
  parameter int FAIL_THRESH = 4,
  parameter int CNT_W       = 8,
  parameter int REHAB       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             sample_i,
  input  logic [W-1:0]     word_i,
  input  logic [W-1:0]     winner_i,
  input  logic             grant_i,
  output rep_state_e       state_o,
  output logic             cand_o,
  output logic             readmit_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int RUN_W = $clog2(FAIL_THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAIL_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rep_state_e       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch;

`ifdef FATORI_MON_READMIT_EN
  localparam int RH_W = $clog2(REHAB + 1);
  logic [RH_W-1:0] rehab_q, rehab_d;
`endif

  always_comb begin
    mismatch  = (word_i != winner_i);
    run_inc   = RUN_W'(sat_inc(32'(run_q), 32'(FAIL_THRESH)));
    state_d   = state_q;
    run_d     = run_q;
    cnt_d     = cnt_q;
    cand_o    = 1'b0;
    readmit_o = 1'b0;
`ifdef FATORI_MON_READMIT_EN
    rehab_d   = rehab_q;
`endif
    if (sample_i) begin
      case (state_q)
        REP_ACTIVE, REP_SUSPECT: begin
          if (mismatch) begin
            cnt_d  = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
            cand_o = (run_inc == RUN_MAX);
            // An ungranted candidate parks at the threshold and retries on its next mismatch.
            if (cand_o && grant_i) begin
              state_d = REP_QUAR;
              run_d   = '0;
            end else begin
              state_d = REP_SUSPECT;
              run_d   = run_inc;
            end
          end else begin
            state_d = REP_ACTIVE;
            run_d   = '0;
          end
        end
        REP_QUAR: begin
`ifdef FATORI_MON_READMIT_EN
          if (mismatch) begin
            rehab_d = '0;
          end else if (rehab_q == RH_W'(REHAB - 1)) begin
            rehab_d   = '0;
            state_d   = REP_ACTIVE;
            readmit_o = 1'b1;
          end else begin
            rehab_d = rehab_q + RH_W'(1);
          end
`else
          state_d = REP_QUAR;
`endif
        end
        default: begin
          state_d = REP_ACTIVE;
          run_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q <= REP_ACTIVE;
      run_q   <= '0;
      cnt_q   <= '0;
`ifdef FATORI_MON_READMIT_EN
      rehab_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
`ifdef FATORI_MON_READMIT_EN
      rehab_q <= rehab_d;
`endif
    end
  end

  assign state_o   = state_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: rtl/fatori_mon_voter_qual.sv
// Sequential M-of-N voter with per-replica fault qualification, quarantine floor and a
// single-entry event slot. Readmission of quarantined replicas via FATORI_MON_READMIT_EN.
module fatori_mon_voter_qual
  import fatori_mon_pkg::*;
#(
  parameter int W           = 32,
  parameter int N           = 3,
  parameter int M           = 2,
  parameter int FAIL_THRESH = 4,
  parameter int CNT_W       = 8,
  parameter int REHAB       = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [N-1:0][W-1:0]        replicas_i,
  input  logic                       clr_i,
  output logic [W-1:0]               y_o,
  output logic                       y_valid_o,
  output logic                       min_err_o,
  output logic                       maj_err_o,
  output logic [N-1:0]               quarantine_o,
  output logic [N-1:0][CNT_W-1:0]    err_cnt_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [$clog2(N)-1:0]       evt_rep_o,
  output evt_kind_e                  evt_kind_o,
  output logic                       evt_drop_o
);

  localparam int IDX_W = $clog2(N);
  localparam int CW    = $clog2(N + 1);
  localparam int NW    = $clog2(2 * N + 1);

  rep_state_e       rep_state [N];
  logic [N-1:0]     active, cand, grant, readmit;
  logic [CW-1:0]    agree, n_act;
  logic             win_found, any_mis, sample;
  logic [W-1:0]     win_word;
  logic [W-1:0]     y_q;
  logic             y_valid_q, min_err_q, maj_err_q;
  logic             evt_valid_q, evt_valid_d, evt_drop_q, evt_drop_d, drain;
  logic [IDX_W-1:0] evt_rep_q, evt_rep_d, new_idx;
  evt_kind_e        evt_kind_q, evt_kind_d, new_kind;
  logic [NW-1:0]    n_new;

  always_comb begin
    win_found = 1'b0;
    win_word  = '0;
    any_mis   = 1'b0;
    agree     = '0;
    for (int i = 0; i < N; i++) begin
      agree = '0;
      for (int j = 0; j < N; j++) begin
        if (active[j] && (replicas_i[j] == replicas_i[i])) begin
          agree = agree + CW'(1);
        end else begin
          agree = agree;
        end
      end
      if (!win_found && active[i] && (agree >= CW'(M))) begin
        win_found = 1'b1;
        win_word  = replicas_i[i];
      end else begin
        win_found = win_found;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (active[i] && (replicas_i[i] != win_word)) begin
        any_mis = 1'b1;
      end else begin
        any_mis = any_mis;
      end
    end
  end

  assign sample = valid_i & win_found;

  for (genvar g = 0; g < N; g++) begin : g_rep
    fatori_mon_rep_tracker #(
      .W(W), .FAIL_THRESH(FAIL_THRESH), .CNT_W(CNT_W), .REHAB(REHAB)
    ) u_trk (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr_i),
      .sample_i  (sample),
      .word_i    (replicas_i[g]),
      .winner_i  (win_word),
      .grant_i   (grant[g]),
      .state_o   (rep_state[g]),
      .cand_o    (cand[g]),
      .readmit_o (readmit[g]),
      .err_cnt_o (err_cnt_o[g])
    );
  end

  // Quarantine grant: lowest-index candidate only, and never below M active replicas.
  always_comb begin
    n_act = '0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      active[i]       = (rep_state[i] != REP_QUAR);
      quarantine_o[i] = (rep_state[i] == REP_QUAR);
      n_act           = n_act + CW'(active[i]);
    end
    for (int i = 0; i < N; i++) begin
      if (cand[i] && (grant == '0) && (n_act > CW'(M))) begin
        grant[i] = 1'b1;
      end else begin
        grant[i] = 1'b0;
      end
    end
  end

  always_comb begin
    new_kind    = EVT_NONE;
    new_idx     = '0;
    n_new       = '0;
    drain       = evt_valid_q & evt_ready_i;
    evt_valid_d = evt_valid_q;
    evt_rep_d   = evt_rep_q;
    evt_kind_d  = evt_kind_q;
    evt_drop_d  = evt_drop_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (readmit[i]) begin
        new_kind = EVT_READMIT;
        new_idx  = IDX_W'(i);
      end else begin
        new_kind = new_kind;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (grant[i]) begin
        new_kind = EVT_QUAR;
        new_idx  = IDX_W'(i);
      end else begin
        new_kind = new_kind;
      end
    end
    for (int i = 0; i < N; i++) begin
      n_new = n_new + NW'(grant[i]) + NW'(readmit[i]);
    end
    // Events that cannot be stored this cycle, including same-cycle extras, raise the sticky drop.
    if (new_kind != EVT_NONE) begin
      if (!evt_valid_q || drain) begin
        evt_valid_d = 1'b1;
        evt_rep_d   = new_idx;
        evt_kind_d  = new_kind;
      end else begin
        evt_drop_d = 1'b1;
      end
      if (n_new > NW'(1)) begin
        evt_drop_d = 1'b1;
      end else begin
        evt_drop_d = evt_drop_d;
      end
    end else if (drain) begin
      evt_valid_d = 1'b0;
      evt_rep_d   = '0;
      evt_kind_d  = EVT_NONE;
    end else begin
      evt_valid_d = evt_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      min_err_q <= 1'b0;
      maj_err_q <= 1'b0;
    end else begin
      y_valid_q <= valid_i;
      min_err_q <= valid_i & win_found & any_mis;
      maj_err_q <= valid_i & ~win_found;
      if (valid_i && win_found) begin
        y_q <= win_word;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      evt_valid_q <= 1'b0;
      evt_rep_q   <= '0;
      evt_kind_q  <= EVT_NONE;
      evt_drop_q  <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_rep_q   <= evt_rep_d;
      evt_kind_q  <= evt_kind_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  assign y_o         = y_q;
  assign y_valid_o   = y_valid_q;
  assign min_err_o   = min_err_q;
  assign maj_err_o   = maj_err_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_rep_o   = evt_rep_q;
  assign evt_kind_o  = evt_kind_q;
  assign evt_drop_o  = evt_drop_q;

endmodule

// File: tb/tb_fatori_mon_voter_qual.sv
// Self-checking bench: a 3-replica instance with a vote scoreboard and a 4-replica instance
// for multi-quarantine, event drop and drain behaviour.
`timescale 1ns/1ps
module tb_fatori_mon_voter_qual;
  import fatori_mon_pkg::*;

  typedef struct packed {
    logic [7:0] y;
    logic       min_e;
    logic       maj_e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1, clr = 1'b0, valid = 1'b0, rdy = 1'b0;
  logic [2:0][7:0]  rep = '0;
  logic [7:0]       y_o;
  logic             y_valid_o, min_err_o, maj_err_o, evt_valid_o, evt_drop_o;
  logic [2:0]       quarantine_o;
  logic [2:0][7:0]  err_cnt_o;
  logic [1:0]       evt_rep_o;
  evt_kind_e        evt_kind_o;

  logic             clr4 = 1'b0, valid4 = 1'b0, rdy4 = 1'b0;
  logic [3:0][7:0]  rep4 = '0;
  logic [7:0]       y4;
  logic             y_valid4, min_err4, maj_err4, evt_valid4, evt_drop4;
  logic [3:0]       quar4;
  logic [3:0][1:0]  err_cnt4;
  logic [1:0]       evt_rep4;
  evt_kind_e        evt_kind4;

  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       sb[$];
  logic [2:0] qmask_m = 3'b000;
  logic [7:0] y_m     = 8'h00;

  fatori_mon_voter_qual #(.W(8), .N(3), .M(2), .FAIL_THRESH(4), .CNT_W(8), .REHAB(8)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .replicas_i(rep), .clr_i(clr),
    .y_o(y_o), .y_valid_o(y_valid_o), .min_err_o(min_err_o), .maj_err_o(maj_err_o),
    .quarantine_o(quarantine_o), .err_cnt_o(err_cnt_o), .evt_valid_o(evt_valid_o),
    .evt_ready_i(rdy), .evt_rep_o(evt_rep_o), .evt_kind_o(evt_kind_o), .evt_drop_o(evt_drop_o)
  );

  fatori_mon_voter_qual #(.W(8), .N(4), .M(2), .FAIL_THRESH(4), .CNT_W(2), .REHAB(8)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid4), .replicas_i(rep4), .clr_i(clr4),
    .y_o(y4), .y_valid_o(y_valid4), .min_err_o(min_err4), .maj_err_o(maj_err4),
    .quarantine_o(quar4), .err_cnt_o(err_cnt4), .evt_valid_o(evt_valid4),
    .evt_ready_i(rdy4), .evt_rep_o(evt_rep4), .evt_kind_o(evt_kind4), .evt_drop_o(evt_drop4)
  );

  function automatic logic [2:0][7:0] pk(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    return {r2, r1, r0};
  endfunction

  function automatic logic [3:0][7:0] pk4(input logic [7:0] r0, input logic [7:0] r1,
                                          input logic [7:0] r2, input logic [7:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  // Reference vote over the replicas the bench believes are still active.
  function automatic exp_t vote_ref(input logic [2:0][7:0] r, input logic [2:0] q, input logic [7:0] prev);
    exp_t e;
    int   votes;
    e.y = prev; e.maj_e = 1'b1; e.min_e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      votes = 0;
      for (int j = 0; j < 3; j++) if (!q[j] && r[j] == r[i]) votes++;
      if (e.maj_e && !q[i] && votes >= 2) begin e.y = r[i]; e.maj_e = 1'b0; end
    end
    if (!e.maj_e) for (int j = 0; j < 3; j++) if (!q[j] && r[j] != e.y) e.min_e = 1'b1;
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [2:0][7:0] r);
    exp_t e, got;
    valid = v; rep = r;
    if (v) begin
      e = vote_ref(r, qmask_m, y_m);
      sb.push_back(e);
      y_m = e.y;
    end
    @(posedge clk); #1;
    valid = 1'b0;
    n_tests++;
    if (y_valid_o !== v) begin n_fail++; $display("FAIL y_valid: got %b want %b", y_valid_o, v); end
    if (y_valid_o === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL sb_empty: output with no expected entry, got y=%h", y_o);
      end else begin
        got = sb.pop_front();
        if ({y_o, min_err_o, maj_err_o} !== got) begin
          n_fail++;
          $display("FAIL vote: got y=%h min=%b maj=%b want y=%h min=%b maj=%b",
                   y_o, min_err_o, maj_err_o, got.y, got.min_e, got.maj_e);
        end
      end
    end else begin
      n_tests++;
      if (min_err_o !== 1'b0 || maj_err_o !== 1'b0 || y_o !== y_m) begin
        n_fail++; $display("FAIL idle: got y=%h min=%b maj=%b want y=%h min=0 maj=0", y_o, min_err_o, maj_err_o, y_m);
      end
    end
  endtask

  task automatic cycle4(input logic v, input logic [3:0][7:0] r);
    valid4 = v; rep4 = r;
    @(posedge clk); #1;
    valid4 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({y_o, y_valid_o, min_err_o, maj_err_o, quarantine_o, err_cnt_o} !== '0) begin
      n_fail++; $display("FAIL reset_out: got y=%h v=%b q=%b cnt=%h want all 0", y_o, y_valid_o, quarantine_o, err_cnt_o);
    end
    n_tests++;
    if ({evt_valid_o, evt_rep_o, evt_kind_o, evt_drop_o, evt_valid4, quar4, err_cnt4} !== '0) begin
      n_fail++; $display("FAIL reset_evt: got ev=%b kind=%0d drop=%b ev4=%b q4=%b want all 0", evt_valid_o, evt_kind_o, evt_drop_o, evt_valid4, quar4);
    end
    rst = 1'b0;
  endtask

  task automatic test_agree;
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
    n_tests++;
    if (quarantine_o !== 3'b000 || err_cnt_o !== '0) begin
      n_fail++; $display("FAIL agree_state: got q=%b cnt=%h want q=000 cnt=0", quarantine_o, err_cnt_o);
    end
    cycle(1'b1, pk(8'h5A, 8'h5A, 8'h5A));
    cycle(1'b0, pk(8'h00, 8'h00, 8'h00));
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
  endtask

  task automatic test_transient;
    cycle(1'b1, pk(8'hA5, 8'h00, 8'hA5));
    n_tests++;
    if (err_cnt_o[1] !== 8'd1) begin n_fail++; $display("FAIL transient_cnt: got %0d want 1", err_cnt_o[1]); end
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
    repeat (3) cycle(1'b1, pk(8'hA5, 8'h00, 8'hA5));
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
    repeat (3) cycle(1'b1, pk(8'hA5, 8'h00, 8'hA5));
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
    n_tests++;
    if (quarantine_o !== 3'b000 || evt_valid_o !== 1'b0 || err_cnt_o[1] !== 8'd7) begin
      n_fail++; $display("FAIL run_reset: got q=%b ev=%b cnt1=%0d want q=000 ev=0 cnt1=7", quarantine_o, evt_valid_o, err_cnt_o[1]);
    end
  endtask

  task automatic test_quarantine;
    repeat (3) cycle(1'b1, pk(8'hA5, 8'hA5, 8'h3C));
    n_tests++;
    if (quarantine_o !== 3'b000) begin n_fail++; $display("FAIL quar_early: got %b want 000", quarantine_o); end
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'h3C));
    qmask_m = 3'b100;
    n_tests++;
    if (quarantine_o !== 3'b100 || err_cnt_o[2] !== 8'd4) begin
      n_fail++; $display("FAIL quar: got q=%b cnt2=%0d want q=100 cnt2=4", quarantine_o, err_cnt_o[2]);
    end
    repeat (2) cycle(1'b0, pk(8'h00, 8'h00, 8'h00));
    n_tests++;
    if (evt_valid_o !== 1'b1 || evt_rep_o !== 2'd2 || evt_kind_o !== EVT_QUAR) begin
      n_fail++; $display("FAIL quar_evt: got v=%b rep=%0d kind=%0d want v=1 rep=2 kind=1", evt_valid_o, evt_rep_o, evt_kind_o);
    end
    rdy = 1'b1;
    cycle(1'b0, pk(8'h00, 8'h00, 8'h00));
    rdy = 1'b0;
    n_tests++;
    if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL evt_drain: got v=%b want 0", evt_valid_o); end
  endtask

  task automatic test_maj_err;
    cycle(1'b1, pk(8'h01, 8'h02, 8'h03));
    n_tests++;
    if (err_cnt_o !== {8'd4, 8'd7, 8'd0}) begin
      n_fail++; $display("FAIL maj_cnt: got %h want 040700", err_cnt_o);
    end
    cycle(1'b1, pk(8'hC3, 8'hC3, 8'h00));
    repeat (10) cycle(1'b1, pk(8'hC3, 8'h5A, 8'hC3));
    n_tests++;
    if (quarantine_o !== 3'b100 || err_cnt_o !== {8'd4, 8'd7, 8'd0}) begin
      n_fail++; $display("FAIL floor: got q=%b cnt=%h want q=100 cnt=040700", quarantine_o, err_cnt_o);
    end
  endtask

  task automatic test_clr;
    clr = 1'b1;
    cycle(1'b1, pk(8'h77, 8'h77, 8'h77));
    clr = 1'b0;
    qmask_m = 3'b000;
    n_tests++;
    if (quarantine_o !== 3'b000 || err_cnt_o !== '0 || evt_valid_o !== 1'b0 || evt_drop_o !== 1'b0) begin
      n_fail++; $display("FAIL clr: got q=%b cnt=%h ev=%b drop=%b want all 0", quarantine_o, err_cnt_o, evt_valid_o, evt_drop_o);
    end
    cycle(1'b1, pk(8'h77, 8'h77, 8'h12));
    n_tests++;
    if (err_cnt_o[2] !== 8'd1) begin n_fail++; $display("FAIL clr_rejoin: got cnt2=%0d want 1", err_cnt_o[2]); end
  endtask

  task automatic test_drop_n4;
    repeat (3) cycle4(1'b1, pk4(8'hAA, 8'hAA, 8'h11, 8'h22));
    n_tests++;
    if (quar4 !== 4'b0000) begin n_fail++; $display("FAIL n4_early: got %b want 0000", quar4); end
    cycle4(1'b1, pk4(8'hAA, 8'hAA, 8'h11, 8'h22));
    n_tests++;
    if (quar4 !== 4'b0100 || evt_valid4 !== 1'b1 || evt_rep4 !== 2'd2 || evt_kind4 !== EVT_QUAR) begin
      n_fail++; $display("FAIL n4_lowest: got q=%b v=%b rep=%0d kind=%0d want q=0100 v=1 rep=2 kind=1", quar4, evt_valid4, evt_rep4, evt_kind4);
    end
    n_tests++;
    if (err_cnt4 !== {2'd3, 2'd3, 2'd0, 2'd0}) begin n_fail++; $display("FAIL n4_sat: got %h want f0", err_cnt4); end
    cycle4(1'b1, pk4(8'hAA, 8'hAA, 8'h11, 8'h22));
    n_tests++;
    if (quar4 !== 4'b1100 || evt_drop4 !== 1'b1 || evt_rep4 !== 2'd2) begin
      n_fail++; $display("FAIL n4_drop: got q=%b drop=%b rep=%0d want q=1100 drop=1 rep=2", quar4, evt_drop4, evt_rep4);
    end
    cycle4(1'b1, pk4(8'hAA, 8'hBB, 8'h00, 8'h00));
    n_tests++;
    if (maj_err4 !== 1'b1 || y4 !== 8'hAA) begin n_fail++; $display("FAIL n4_maj: got maj=%b y=%h want maj=1 y=aa", maj_err4, y4); end
    repeat (5) cycle4(1'b1, pk4(8'hAA, 8'hBB, 8'h00, 8'h00));
    n_tests++;
    if (quar4 !== 4'b1100 || err_cnt4[1] !== 2'd0) begin
      n_fail++; $display("FAIL n4_floor: got q=%b cnt1=%0d want q=1100 cnt1=0", quar4, err_cnt4[1]);
    end
    clr4 = 1'b1;
    cycle4(1'b0, pk4(8'h00, 8'h00, 8'h00, 8'h00));
    clr4 = 1'b0;
    n_tests++;
    if (quar4 !== 4'b0000 || err_cnt4 !== '0 || evt_valid4 !== 1'b0 || evt_drop4 !== 1'b0) begin
      n_fail++; $display("FAIL n4_clr: got q=%b cnt=%h v=%b drop=%b want all 0", quar4, err_cnt4, evt_valid4, evt_drop4);
    end
    repeat (4) cycle4(1'b1, pk4(8'hAA, 8'hAA, 8'hAA, 8'h22));
    repeat (3) cycle4(1'b1, pk4(8'hAA, 8'hAA, 8'h22, 8'hAA));
    n_tests++;
    if (evt_valid4 !== 1'b1 || evt_rep4 !== 2'd3 || quar4 !== 4'b1000) begin
      n_fail++; $display("FAIL n4_evt3: got v=%b rep=%0d q=%b want v=1 rep=3 q=1000", evt_valid4, evt_rep4, quar4);
    end
    rdy4 = 1'b1;
    cycle4(1'b1, pk4(8'hAA, 8'hAA, 8'h22, 8'hAA));
    rdy4 = 1'b0;
    n_tests++;
    if (evt_valid4 !== 1'b1 || evt_rep4 !== 2'd2 || evt_drop4 !== 1'b0 || quar4 !== 4'b1100) begin
      n_fail++; $display("FAIL n4_drain_load: got v=%b rep=%0d drop=%b q=%b want v=1 rep=2 drop=0 q=1100", evt_valid4, evt_rep4, evt_drop4, quar4);
    end
  endtask

`ifdef FATORI_MON_READMIT_EN
  task automatic test_readmit;
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
    repeat (4) cycle(1'b1, pk(8'hA5, 8'hA5, 8'h3C));
    qmask_m = 3'b100;
    rdy = 1'b1;
    cycle(1'b0, pk(8'h00, 8'h00, 8'h00));
    rdy = 1'b0;
    repeat (3) cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'h00));
    repeat (7) cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
    n_tests++;
    if (quarantine_o !== 3'b100) begin n_fail++; $display("FAIL rehab_early: got %b want 100", quarantine_o); end
    cycle(1'b1, pk(8'hA5, 8'hA5, 8'hA5));
    qmask_m = 3'b000;
    n_tests++;
    if (quarantine_o !== 3'b000 || evt_valid_o !== 1'b1 || evt_kind_o !== EVT_READMIT || evt_rep_o !== 2'd2) begin
      n_fail++; $display("FAIL readmit: got q=%b v=%b kind=%0d rep=%0d want q=000 v=1 kind=2 rep=2", quarantine_o, evt_valid_o, evt_kind_o, evt_rep_o);
    end
  endtask
`endif

  task automatic test_reset_mid;
    repeat (2) cycle(1'b1, pk(8'h11, 8'hA5, 8'hA5));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    y_m = 8'h00;
    qmask_m = 3'b000;
    n_tests++;
    if (err_cnt_o !== '0 || y_o !== 8'h00 || evt_valid4 !== 1'b0 || quar4 !== 4'b0000 || sb.size() != 0) begin
      n_fail++; $display("FAIL reset_mid: got cnt=%h y=%h ev4=%b q4=%b sb=%0d want all 0", err_cnt_o, y_o, evt_valid4, quar4, sb.size());
    end
    cycle(1'b1, pk(8'h3C, 8'h3C, 8'h3C));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_agree();
    test_transient();
    test_quarantine();
    test_maj_err();
    test_clr();
    test_drop_n4();
`ifdef FATORI_MON_READMIT_EN
    test_readmit();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
